// File: rtl/ewb_multi_if.sv
// Bus bundle for the multi-entry eviction write buffer: cache-facing and
// arbiter-facing signals. The slave modport is the buffer's view.
interface ewb_multi_if #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] cache_address;
    logic              cache_read;
    logic              cache_write;
    logic [LINE_W-1:0] cache_wdata;
    logic [LINE_W-1:0] ewb_rdata;
    logic              ewb_resp;

    logic [LINE_W-1:0] arbiter_rdata;
    logic              arbiter_resp;
    logic              ewb_read;
    logic              ewb_write;
    logic [ADDR_W-1:0] ewb_address;
    logic [LINE_W-1:0] ewb_wdata;

    logic [CNT_W-1:0]  ewb_count;
    logic              ewb_full;
    logic              ewb_empty;

    modport slave (
        input  cache_address, cache_read, cache_write, cache_wdata,
        input  arbiter_rdata, arbiter_resp,
        output ewb_rdata, ewb_resp, ewb_read, ewb_write, ewb_address, ewb_wdata,
        output ewb_count, ewb_full, ewb_empty
    );

    modport master (
        output cache_address, cache_read, cache_write, cache_wdata,
        output arbiter_rdata, arbiter_resp,
        input  ewb_rdata, ewb_resp, ewb_read, ewb_write, ewb_address, ewb_wdata,
        input  ewb_count, ewb_full, ewb_empty
    );
endinterface

// File: rtl/ewb_multi.sv
// Multi-entry eviction write buffer: FIFO of dirty victim lines with read-hit
// forwarding and write merging. Define EWB_PERF_CNT_EN for hit/merge/drain counters.
module ewb_multi #(
    parameter int DEPTH  = 4,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    ewb_multi_if.slave  bus
`ifdef EWB_PERF_CNT_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] merge_count,
    output logic [31:0] drain_count
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t                        state;
    logic [DEPTH-1:0]              valid;
    logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
    logic [DEPTH-1:0][LINE_W-1:0]  data_q;
    logic [PW-1:0]                 head;
    logic [PW-1:0]                 tail;
    logic [CW-1:0]                 count;

    logic [DEPTH-1:0]              hit_vec;
    logic                          hit;
    logic [PW-1:0]                 hit_idx;
    logic                          full;

    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        assign hit_vec[k] = valid[k] && (addr_q[k] == bus.cache_address);
    end

    // At most one entry can match, so a priority scan doubles as an encoder.
    always_comb begin
        hit_idx = '0;
        for (int k = 0; k < DEPTH; k++)
            if (hit_vec[k]) hit_idx = PW'(k);
    end

    assign hit            = |hit_vec;
    assign full           = (count == CW'(DEPTH));
    assign bus.ewb_count  = count;
    assign bus.ewb_full   = full;
    assign bus.ewb_empty  = (count == '0);

    always_comb begin
        bus.ewb_rdata   = '0;
        bus.ewb_resp    = 1'b0;
        bus.ewb_read    = 1'b0;
        bus.ewb_write   = 1'b0;
        bus.ewb_address = '0;
        bus.ewb_wdata   = '0;
        case (state)
            IDLE: begin
                if (bus.cache_write) begin
                    bus.ewb_resp = hit || !full;
                end else if (bus.cache_read && hit) begin
                    bus.ewb_resp  = 1'b1;
                    bus.ewb_rdata = data_q[hit_idx];
                end
            end
            READ: begin
                bus.ewb_read    = 1'b1;
                bus.ewb_address = bus.cache_address;
                bus.ewb_rdata   = bus.arbiter_rdata;
                bus.ewb_resp    = bus.arbiter_resp;
            end
            DRAIN: begin
                bus.ewb_write   = 1'b1;
                bus.ewb_address = addr_q[head];
                bus.ewb_wdata   = data_q[head];
            end
            default: ;
        endcase
    end

    // Line storage is not cleared on reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cache_write) begin
                        if (hit) begin
                            data_q[hit_idx] <= bus.cache_wdata;
                        end else if (!full) begin
                            valid[tail]  <= 1'b1;
                            addr_q[tail] <= bus.cache_address;
                            data_q[tail] <= bus.cache_wdata;
                            tail         <= tail + 1'b1;
                            count        <= count + 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (bus.cache_read) begin
                        if (!hit) state <= READ;
                    end else if (count != '0) begin
                        state <= DRAIN;
                    end
                end
                READ: begin
                    if (bus.arbiter_resp) state <= IDLE;
                end
                DRAIN: begin
                    if (bus.arbiter_resp) begin
                        valid[head] <= 1'b0;
                        head        <= head + 1'b1;
                        count       <= count - 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EWB_PERF_CNT_EN
    logic ev_hit, ev_merge, ev_drain;

    assign ev_hit   = (state == IDLE) && !bus.cache_write && bus.cache_read && hit;
    assign ev_merge = (state == IDLE) && bus.cache_write && hit;
    assign ev_drain = (state == DRAIN) && bus.arbiter_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count   <= '0;
            merge_count <= '0;
            drain_count <= '0;
        end else begin
            if (ev_hit   && hit_count   != '1) hit_count   <= hit_count + 1'b1;
            if (ev_merge && merge_count != '1) merge_count <= merge_count + 1'b1;
            if (ev_drain && drain_count != '1) drain_count <= drain_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ewb_multi.sv
// Self-checking bench for ewb_multi: vector table for hit/merge traffic,
// scripted sequences for full-stall, read-miss and reset-during-drain.
module tb_ewb_multi;
    localparam int DEPTH  = 4;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ewb_multi_if #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();
    ewb_multi #(.DEPTH(DEPTH), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchk  = 0;
    int nfail = 0;

    task automatic check_i(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_l(input string name, input logic [LINE_W-1:0] act,
                           input logic [LINE_W-1:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] line(input logic [31:0] s);
        return {8{s}};
    endfunction

    function automatic logic [LINE_W-1:0] mem_line(input logic [ADDR_W-1:0] a);
        return {8{a ^ 32'hA5A5_0000}};
    endfunction

    // Scoreboard of expected cache-side responses.
    typedef struct {
        logic              is_read;
        logic [LINE_W-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.ewb_resp) begin
            if (sb.size() == 0) begin
                nchk++;
                nfail++;
                $display("FAIL unexpected_resp: got resp with no pending request");
            end else begin
                e = sb.pop_front();
                if (e.is_read) check_l("read_data", bus.ewb_rdata, e.rdata);
            end
        end
    end

    // Arbiter model: answers after arb_lat request cycles, logs completed drains.
    int  arb_lat   = 2;
    bit  arb_en    = 1'b1;
    int  req_cyc   = 0;
    int  rd_cycles = 0;
    logic [ADDR_W-1:0] drain_addr[$];
    logic [LINE_W-1:0] drain_data[$];

    initial begin
        bus.arbiter_resp  = 1'b0;
        bus.arbiter_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.ewb_read) rd_cycles++;
            if (arb_en && (bus.ewb_read || bus.ewb_write)) begin
                bus.arbiter_rdata = mem_line(bus.ewb_address);
                bus.arbiter_resp  = (req_cyc == arb_lat - 1);
                if (bus.arbiter_resp && bus.ewb_write) begin
                    drain_addr.push_back(bus.ewb_address);
                    drain_data.push_back(bus.ewb_wdata);
                end
                req_cyc = bus.arbiter_resp ? 0 : req_cyc + 1;
            end else begin
                bus.arbiter_resp = 1'b0;
                req_cyc          = 0;
            end
        end
    end

    // Entered and left at posedge+1; request stays asserted until its response.
    // op: 1 write, 2 read, 3 read+write together.
    task automatic req(input int op, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                       input logic [LINE_W-1:0] exp_rd, output int lat, output int cnt_at_resp);
        exp_t e;
        bus.cache_address = a;
        bus.cache_wdata   = d;
        bus.cache_write   = (op == 1 || op == 3);
        bus.cache_read    = (op >= 2);
        e.is_read = (op == 2);
        e.rdata   = exp_rd;
        sb.push_back(e);
        lat         = 0;
        cnt_at_resp = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.ewb_resp) begin
                lat         = c;
                cnt_at_resp = int'(bus.ewb_count);
            end
            @(posedge clk);
            #1;
            if (lat != 0) break;
        end
        if (lat == 0) begin
            nchk++;
            nfail++;
            $display("FAIL req_timeout: got no resp for addr %0h expected one within 40 cycles", a);
            sb.delete();
        end
        bus.cache_write = 1'b0;
        bus.cache_read  = 1'b0;
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.cache_read    = 1'b0;
        bus.cache_write   = 1'b0;
        bus.cache_address = '0;
        bus.cache_wdata   = '0;
        sb.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        int                op;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       seed;
        logic [31:0]       rd_seed;
        int                exp_lat;
        int                exp_cnt;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 ns");
        $fatal(1);
    end

    initial begin
        int lat, cres, rd0;
        bit done;

        tbl[0] = '{1, 32'h100, 32'hAAAA_0001, 32'h0,         1, 1};
        tbl[1] = '{2, 32'h100, 32'h0,         32'hAAAA_0001, 1, 1};
        tbl[2] = '{1, 32'h100, 32'hBBBB_0002, 32'h0,         1, 1};
        tbl[3] = '{2, 32'h100, 32'h0,         32'hBBBB_0002, 1, 1};
        tbl[4] = '{3, 32'h140, 32'hCCCC_0003, 32'h0,         1, 2};
        tbl[5] = '{2, 32'h140, 32'h0,         32'hCCCC_0003, 1, 2};

        do_reset();
        check_i("rst_resp",    int'(bus.ewb_resp), 0);
        check_i("rst_read",    int'(bus.ewb_read), 0);
        check_i("rst_write",   int'(bus.ewb_write), 0);
        check_i("rst_address", int'(bus.ewb_address), 0);
        check_l("rst_wdata",   bus.ewb_wdata, '0);
        check_l("rst_rdata",   bus.ewb_rdata, '0);
        check_i("rst_count",   int'(bus.ewb_count), 0);
        check_i("rst_empty",   int'(bus.ewb_empty), 1);
        check_i("rst_full",    int'(bus.ewb_full), 0);

        // Back-to-back hit/merge traffic: no idle gap, so nothing drains.
        for (int i = 0; i < 6; i++) begin
            req(tbl[i].op, tbl[i].addr, line(tbl[i].seed), line(tbl[i].rd_seed), lat, cres);
            check_i($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
            check_i($sformatf("vec%0d_count", i), int'(bus.ewb_count), tbl[i].exp_cnt);
        end
        check_i("hits_no_arb_read", rd_cycles, 0);

        // Idle: both entries drain in FIFO order with merged data.
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            done = bus.ewb_empty;
        end
        check_i("drain_to_empty", int'(done), 1);
        check_i("drain_n", drain_addr.size(), 2);
        if (drain_addr.size() >= 2) begin
            check_i("drain0_addr", int'(drain_addr[0]), 32'h100);
            check_l("drain0_data", drain_data[0], line(32'hBBBB_0002));
            check_i("drain1_addr", int'(drain_addr[1]), 32'h140);
            check_l("drain1_data", drain_data[1], line(32'hCCCC_0003));
        end

        // Fill to DEPTH, then a miss write stalls behind one forced drain.
        drain_addr.delete();
        drain_data.delete();
        arb_lat = 3;
        for (int i = 0; i < 4; i++) begin
            req(1, ADDR_W'(i * 32'h20), line(32'hF000 + i), '0, lat, cres);
            check_i($sformatf("fill%0d_lat", i), lat, 1);
        end
        check_i("fill_count", int'(bus.ewb_count), 4);
        check_i("fill_full",  int'(bus.ewb_full), 1);
        req(1, 32'h80, line(32'hF080), '0, lat, cres);
        check_i("stall_lat", lat, 5);
        check_i("stall_count_at_resp", cres, 3);
        check_i("stall_count_after", int'(bus.ewb_count), 4);
        check_i("stall_drain_n", drain_addr.size(), 1);
        if (drain_addr.size() >= 1) begin
            check_i("stall_drain_addr", int'(drain_addr[0]), 0);
            check_l("stall_drain_data", drain_data[0], line(32'hF000));
        end
        req(2, 32'h80, '0, line(32'hF080), lat, cres);
        check_i("stall_readback_lat", lat, 1);

        // Read miss with two buffered entries: forwarded from arbiter.
        do_reset();
        arb_lat = 5;
        req(1, 32'h300, line(32'hD001), '0, lat, cres);
        req(1, 32'h320, line(32'hD002), '0, lat, cres);
        rd0 = rd_cycles;
        req(2, 32'h200, '0, mem_line(32'h200), lat, cres);
        check_i("miss_lat", lat, 6);
        check_i("miss_read_cycles", rd_cycles - rd0, 5);
        check_i("miss_count", int'(bus.ewb_count), 2);
        rd0 = rd_cycles;
        req(2, 32'h300, '0, line(32'hD001), lat, cres);
        check_i("post_miss_hit_lat", lat, 1);
        check_i("post_miss_no_read", rd_cycles - rd0, 0);

        // Reset while a drain is outstanding and the arbiter never answers.
        arb_en = 1'b0;
        done   = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(posedge clk);
            #1;
            done = bus.ewb_write;
        end
        check_i("hung_drain_started", int'(done), 1);
        check_i("hung_drain_addr", int'(bus.ewb_address), 32'h300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_i("rst_drain_write", int'(bus.ewb_write), 0);
        check_i("rst_drain_count", int'(bus.ewb_count), 0);
        check_i("rst_drain_empty", int'(bus.ewb_empty), 1);
        rst     = 1'b0;
        arb_en  = 1'b1;
        arb_lat = 2;
        rd0     = rd_cycles;
        req(2, 32'h300, '0, mem_line(32'h300), lat, cres);
        check_i("rst_old_addr_miss_lat", lat, 3);
        check_i("rst_old_addr_read_cycles", rd_cycles - rd0, 2);

        repeat (2) @(posedge clk);
        check_i("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
